// File: rtl/flex_counter_ud_if.sv
// Control/status bundle for the flex up/down counter.
// The master drives the controls; the slave (the counter) returns the count and flags.
interface flex_counter_ud_if #(
  parameter int N = 4
);
  logic         clear;
  logic         load;
  logic [N-1:0] load_val;
  logic         count_enable;
  logic         count_up;
  logic         saturate;
  logic [N-1:0] rollover_val;
  logic [N-1:0] count_out;
  logic         rollover_flag;
  logic         zero_flag;
  logic         wrap_pulse;

  modport master (
    output clear, load, load_val,
    output count_enable, count_up,
    output saturate, rollover_val,
    input  count_out, rollover_flag,
    input  zero_flag, wrap_pulse
  );

  modport slave (
    input  clear, load, load_val,
    input  count_enable, count_up,
    input  saturate, rollover_val,
    output count_out, rollover_flag,
    output zero_flag, wrap_pulse
  );
endinterface

// File: rtl/flex_counter_ud.sv
// Up/down counter with load, wrap or saturate limits and
// registered flags aligned with the count value.
module flex_counter_ud #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  flex_counter_ud_if.slave bus
);
  localparam int N = NUM_CNT_BITS;

  logic [N-1:0] cnt_q, cnt_d;
  logic         roll_q, roll_d;
  logic         zero_q, zero_d;
  logic         wrap_q, wrap_d;
  logic [N-1:0] rv;

  assign rv = bus.rollover_val;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.clear) begin
      cnt_d = '0;
    end else if (bus.load) begin
      cnt_d = (bus.load_val > rv) ? rv : bus.load_val;
    end else if (bus.count_enable) begin
      if (bus.count_up) begin
        if (cnt_q < rv) begin
          cnt_d = cnt_q + 1'b1;
        end else if (bus.saturate) begin
          cnt_d = rv;
        end else begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        // out-of-range counts snap back to the limit
        if (cnt_q > rv) begin
          cnt_d = rv;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!bus.saturate) begin
          cnt_d  = rv;
          wrap_d = 1'b1;
        end
      end
    end
    roll_d = (cnt_d == rv);
    zero_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      roll_q <= 1'b0;
      zero_q <= 1'b1;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      roll_q <= roll_d;
      zero_q <= zero_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.count_out     = cnt_q;
  assign bus.rollover_flag = roll_q;
  assign bus.zero_flag     = zero_q;
  assign bus.wrap_pulse    = wrap_q;
endmodule

// File: tb/tb_flex_counter_ud.sv
// Scoreboard bench for flex_counter_ud: a behavioural model
// queues expected outputs, compared one edge later.
module tb_flex_counter_ud;
  typedef struct packed {
    logic [3:0] cnt;
    logic       roll;
    logic       zero;
    logic       wrap;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sbq[$];
  logic [3:0] m_cnt;

  flex_counter_ud_if #(.N(4)) bus ();

  flex_counter_ud #(.NUM_CNT_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(logic [3:0] c);
    exp_t e;
    logic [3:0] r;
    r = bus.rollover_val;
    e.cnt  = c;
    e.wrap = 1'b0;
    if (bus.clear) e.cnt = 4'd0;
    else if (bus.load)
      e.cnt = (bus.load_val > r) ? r : bus.load_val;
    else if (bus.count_enable) begin
      if (bus.count_up) begin
        if (c < r) e.cnt = c + 4'd1;
        else if (bus.saturate) e.cnt = r;
        else begin e.cnt = 4'd0; e.wrap = 1'b1; end
      end else begin
        if (c > r) e.cnt = r;
        else if (c != 4'd0) e.cnt = c - 4'd1;
        else if (!bus.saturate) begin e.cnt = r; e.wrap = 1'b1; end
      end
    end
    e.roll = (e.cnt == r);
    e.zero = (e.cnt == 4'd0);
    return e;
  endfunction

  task automatic step(string tag);
    exp_t e;
    e = model(m_cnt);
    m_cnt = e.cnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, "_sbq_empty"}, 1, 0);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_cnt"}, bus.count_out, e.cnt);
      chk({tag, "_roll"}, bus.rollover_flag, e.roll);
      chk({tag, "_zero"}, bus.zero_flag, e.zero);
      chk({tag, "_wrap"}, bus.wrap_pulse, e.wrap);
    end
  endtask

  task automatic ctl(logic cl, logic ld, logic [3:0] lv,
                     logic en, logic up, logic sat, logic [3:0] r);
    bus.clear        = cl;
    bus.load         = ld;
    bus.load_val     = lv;
    bus.count_enable = en;
    bus.count_up     = up;
    bus.saturate     = sat;
    bus.rollover_val = r;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_cnt  = 4'd0;
    ctl(0, 0, 0, 0, 1, 0, 4'd5);
    rst = 1'b1;
    #12;
    chk("rst_cnt", bus.count_out, 0);
    chk("rst_zero", bus.zero_flag, 1);
    chk("rst_roll", bus.rollover_flag, 0);
    chk("rst_wrap", bus.wrap_pulse, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // up count with wrap, R=5
    ctl(0, 0, 0, 1, 1, 0, 4'd5);
    for (int i = 0; i < 5; i++) step("upw");
    chk("upw_at5", bus.count_out, 5);
    chk("upw_roll5", bus.rollover_flag, 1);
    step("upw");
    chk("upw_at0", bus.count_out, 0);
    chk("upw_pulse", bus.wrap_pulse, 1);

    // saturate both directions, R=3
    ctl(0, 0, 0, 1, 1, 1, 4'd3);
    for (int i = 0; i < 6; i++) step("satup");
    chk("satup_hold", bus.count_out, 3);
    ctl(0, 0, 0, 1, 0, 1, 4'd3);
    for (int i = 0; i < 6; i++) step("satdn");
    chk("satdn_hold", bus.count_out, 0);
    chk("satdn_zero", bus.zero_flag, 1);

    // down wrap, R=9
    ctl(0, 0, 0, 1, 0, 0, 4'd9);
    step("dnw");
    chk("dnw_at9", bus.count_out, 9);
    chk("dnw_pulse", bus.wrap_pulse, 1);
    ctl(0, 0, 0, 0, 0, 0, 4'd9);
    step("hold");

    // priority and clamp
    ctl(1, 1, 4'd7, 1, 1, 0, 4'd10);
    step("prio_clr");
    chk("prio_clr0", bus.count_out, 0);
    ctl(0, 1, 4'd12, 0, 1, 0, 4'd10);
    step("clamp");
    chk("clamp10", bus.count_out, 10);
    ctl(0, 1, 4'd4, 1, 1, 0, 4'd10);
    step("ld_en");
    chk("ld_en4", bus.count_out, 4);

    // R=15 full-range wrap
    ctl(0, 1, 4'd15, 0, 1, 0, 4'd15);
    step("r15_ld");
    ctl(0, 0, 0, 1, 1, 0, 4'd15);
    step("r15_wrap");
    chk("r15_at0", bus.count_out, 0);
    chk("r15_pulse", bus.wrap_pulse, 1);

    // R=0, enable held: pulse stays high
    ctl(0, 0, 0, 1, 1, 0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step("r0");
      chk("r0_pulse", bus.wrap_pulse, 1);
    end

    // lower limit below current count
    ctl(0, 1, 4'd8, 0, 1, 0, 4'd15);
    step("oor_ld");
    ctl(0, 0, 0, 1, 1, 0, 4'd4);
    step("oor_up");
    chk("oor_up0", bus.count_out, 0);
    chk("oor_up_pulse", bus.wrap_pulse, 1);
    ctl(0, 1, 4'd8, 0, 1, 0, 4'd15);
    step("oor_ld2");
    ctl(0, 0, 0, 1, 0, 0, 4'd4);
    step("oor_dn");
    chk("oor_dn4", bus.count_out, 4);
    chk("oor_dn_nopulse", bus.wrap_pulse, 0);

    // async reset mid-run
    ctl(1, 0, 0, 0, 1, 0, 4'd15);
    step("ar_clr");
    ctl(0, 0, 0, 1, 1, 0, 4'd15);
    for (int i = 0; i < 6; i++) step("ar_up");
    #2;
    rst = 1'b1;
    #1;
    chk("ar_cnt", bus.count_out, 0);
    chk("ar_zero", bus.zero_flag, 1);
    chk("ar_roll", bus.rollover_flag, 0);
    #1;
    rst = 1'b0;
    m_cnt = 4'd0;
    step("ar_resume");
    chk("ar_resume1", bus.count_out, 1);

    // random mix against the model
    for (int i = 0; i < 300; i++) begin
      ctl(($urandom_range(0, 15) == 0),
          ($urandom_range(0, 7) == 0),
          4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) == 0) ?
            4'($urandom_range(0, 15)) : bus.rollover_val);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flex_counter_ud.md
# flex_counter_ud

Parametrised up/down counter with synchronous load, selectable wrap or saturate limit behaviour, and registered terminal and zero flags aligned with the count value. It is the general-purpose successor to the basic up-only rollover counter. It serves as the timing and bit-count building block for protocol FSMs, baud/sample timers and FIFO occupancy tracking across the design. Flags and the wrap pulse are cycle-aligned with `count_out`, so downstream logic needs no compensation delay.

## Interface
- `NUM_CNT_BITS`, 4: counter width N; must be ≥ 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clear` input 1: synchronous clear of the count to 0.
- `load` input 1: synchronous load of `load_val`.
- `load_val` input N: value to load, clamped to `rollover_val`.
- `count_enable` input 1: advance the count by one step this cycle.
- `count_up` input 1: direction; 1 = increment, 0 = decrement.
- `saturate` input 1: limit mode; 1 = hold at the limit, 0 = wrap.
- `rollover_val` input N: upper limit; legal count range is 0..`rollover_val`.
- `count_out` output N: registered count.
- `rollover_flag` output 1: registered; high iff `count_out == rollover_val`, with `rollover_val` sampled at the last edge.
- `zero_flag` output 1: registered; high iff `count_out == 0`.
- `wrap_pulse` output 1: registered; high for the cycle in which `count_out` holds a value produced by a wrap.

## Operation
- **Priority, per edge:** `rst` > `clear` > `load` > `count_enable` > hold.
- **Reset:** while `rst` is high, regardless of the clock:
  - `count_out` = 0, `zero_flag` = 1.
  - `rollover_flag` = 0, `wrap_pulse` = 0.
- **clear:** next count = 0; `wrap_pulse` next = 0.
- **load:** next count = `load_val` if `load_val` ≤ `rollover_val`, else `rollover_val`; `wrap_pulse` next = 0.
- **Count up** (`count_enable` = 1, `count_up` = 1):
  - `count_out` < `rollover_val`: next = `count_out` + 1.
  - `count_out` ≥ `rollover_val`, wrap mode: next = 0; `wrap_pulse` next = 1.
  - `count_out` ≥ `rollover_val`, saturate mode: next = `rollover_val`; no pulse.
- **Count down** (`count_enable` = 1, `count_up` = 0):
  - `count_out` > `rollover_val`: next = `rollover_val`; no pulse. This is the out-of-range recovery case.
  - 0 < `count_out` ≤ `rollover_val`: next = `count_out` − 1.
  - `count_out` = 0, wrap mode: next = `rollover_val`; `wrap_pulse` next = 1.
  - `count_out` = 0, saturate mode: hold at 0; no pulse.
- **Hold** (no control active): count unchanged; `wrap_pulse` next = 0.
- **Flag computation:** flags are registered from the next count and the current `rollover_val`, and are updated every edge including hold cycles. They therefore always describe `count_out` as presented.
- **Arithmetic:** N-bit unsigned throughout.
  - No intermediate value wraps through 2^N; the limit checks above guarantee this.
  - For `rollover_val` = 2^N − 1, up wrap goes 2^N − 1 → 0 through the limit path, not through arithmetic overflow.
- **rollover_val = 0:**
  - Count is pinned at 0; `rollover_flag` = `zero_flag` = 1.
  - Wrap mode: every enabled cycle is a wrap, so `wrap_pulse` stays high continuously while `count_enable` is held.
- **Changing rollover_val mid-run:**
  - Takes effect on the next edge; no glitch on registered outputs.
  - A count left above the new limit is handled by the out-of-range rules above.

## Timing
- **Latency:** one cycle from any control input (`clear`, `load`, `count_enable`, `count_up`, `saturate`, `rollover_val`) to `count_out` and all flags.
- **Outputs:** all are flop outputs with no combinational path from inputs.
- **wrap_pulse:** asserted in the same cycle the wrapped value (0 for up, `rollover_val` for down) appears on `count_out`. It is exactly one cycle wide unless the next edge is also a wrap.
- **Wrap period:** with enable held, up/wrap mode and `rollover_val` = R, the period is R + 1 cycles.
- **Direction change:** takes effect on the edge where `count_up` is sampled. There is no turnaround cycle.
- **Reset mid-count:** asynchronous assertion forces all outputs to their reset values immediately. Counting resumes on the first edge after deassertion.

## Test plan
- **Reset then up-count wrap:** reset, R = 5, wrap mode, enable held up → `count_out` 0,1,2,3,4,5,0. `rollover_flag` high with 5. `wrap_pulse` high only with the 0 after 5.
- **Saturate both directions:** saturate, R = 3, up enable for 6 cycles → count stops at 3, `rollover_flag` stays 1, `wrap_pulse` never 1. Then down for 6 cycles → stops at 0, `zero_flag` = 1.
- **Down wrap:** wrap mode, R = 9, count at 0, `count_up` = 0 for 1 cycle → `count_out` = 9, `wrap_pulse` = 1, `rollover_flag` = 1.
- **Priority and clamp:**
  - `clear`, `load` and `count_enable` all high with `load_val` = 7 → `count_out` = 0.
  - Then `load` with `load_val` = 12, R = 10 → `count_out` = 10.
  - Then `load` and `count_enable` high with `load_val` = 4 → `count_out` = 4, with no increment.
- **Corner limits:**
  - N = 4, R = 15, up wrap → 15 → 0 with pulse.
  - R = 0, enable held → count 0, `wrap_pulse` continuously 1.
  - Count 8, R lowered to 4: up → 0 with pulse; down → 4, no pulse.
- **Async reset mid-run:** assert `rst` between edges at count 6 → `count_out` = 0 and `zero_flag` = 1 before the next edge. After release, the count sequence restarts at 1.
